// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch request handshake and redirect strobes between pc_gen and its neighbours.
// master = pc_gen (drives the fetch request), slave = fetch/decode/execute side.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            br_valid;
  logic [XLEN-1:0] br_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            req_ready;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] pc_nxt;
  logic            misalign_fault;

  modport master (
    input  stall, br_valid, br_pc, trap_valid, trap_pc, req_ready,
    output req_valid, req_pc, pc_nxt, misalign_fault
  );

  modport slave (
    output stall, br_valid, br_pc, trap_valid, trap_pc, req_ready,
    input  req_valid, req_pc, pc_nxt, misalign_fault
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter / fetch request generator with branch+trap redirects and a pending slot.
// Define PC_GEN_ALIGN_CHK_EN to drop misaligned redirect targets and pulse misalign_fault.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     INC       = 4
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          r_state, w_state_d;
  logic [XLEN-1:0] r_pc, w_pc_d;
  logic [XLEN-1:0] r_pend_pc, w_pend_pc_d;
  logic            r_pend_valid, w_pend_valid_d;
  logic            r_pend_trap, w_pend_trap_d;

  logic            w_req_valid;
  logic [XLEN-1:0] w_target;
  logic            w_misalign;
  logic            w_redir;
  logic            w_redir_trap;
  logic            w_load;
  logic [XLEN-1:0] w_load_pc;

  // Trap wins over branch when both strobe in the same cycle.
  assign w_target = bus.trap_valid ? bus.trap_pc : bus.br_pc;

`ifdef PC_GEN_ALIGN_CHK_EN
  assign w_misalign = (bus.trap_valid | bus.br_valid) && (w_target[1:0] != 2'b00)
                      && (r_state != BOOT);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_redir      = (bus.trap_valid | bus.br_valid) && !w_misalign;
  assign w_redir_trap = w_redir && bus.trap_valid;

  // Target to load when the PC is allowed to move: a pending trap outranks a fresh branch.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_load    = 1'b1;
    w_load_pc = w_target;
    if (w_redir_trap) begin
      w_load_pc = w_target;
    end else if (r_pend_valid && r_pend_trap) begin
      w_load_pc = r_pend_pc;
    end else if (w_redir) begin
      w_load_pc = w_target;
    end else if (r_pend_valid) begin
      w_load_pc = r_pend_pc;
    end else begin
      w_load = 1'b0;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_req_valid    = 1'b0;
    w_pc_d         = r_pc;
    w_pend_valid_d = r_pend_valid;
    w_pend_pc_d    = r_pend_pc;
    w_pend_trap_d  = r_pend_trap;
    unique case (r_state)
      BOOT: w_state_d = RUN;
      RUN: begin
        w_req_valid = 1'b1;
        if (bus.req_ready) begin
          w_pc_d         = w_load ? w_load_pc : r_pc + XLEN'(INC);
          w_pend_valid_d = 1'b0;
          w_pend_trap_d  = 1'b0;
          if (bus.stall) w_state_d = HOLD;
        end else if (w_redir && !(r_pend_valid && r_pend_trap && !w_redir_trap)) begin
          // Request not yet accepted: park the target until the handshake.
          w_pend_valid_d = 1'b1;
          w_pend_pc_d    = w_target;
          w_pend_trap_d  = w_redir_trap;
        end
      end
      HOLD: begin
        if (w_load) w_pc_d = w_load_pc;
        w_pend_valid_d = 1'b0;
        w_pend_trap_d  = 1'b0;
        if (!bus.stall) w_state_d = RUN;
      end
      default: w_state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= BOOT;
      r_pc         <= RESET_VEC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_pend_trap  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      r_state      <= w_state_d;
      r_pc         <= w_pc_d;
      r_pend_valid <= w_pend_valid_d;
      r_pend_pc    <= w_pend_pc_d;
      r_pend_trap  <= w_pend_trap_d;
    end
  end

`ifdef PC_GEN_ALIGN_CHK_EN
  logic r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fault <= 1'b0;
    else     r_fault <= w_misalign;
  end

  assign bus.misalign_fault = r_fault;
`else
  assign bus.misalign_fault = 1'b0;
`endif

  assign bus.req_valid = w_req_valid;
  assign bus.req_pc    = r_pc;
  assign bus.pc_nxt    = r_pc + XLEN'(INC);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen; a second instance checks PC wrap-around.
// Expected values follow PC_GEN_ALIGN_CHK_EN when the bench is built with it.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) bus ();
  pc_gen_if #(.XLEN(32)) wbus ();

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .INC(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'hFFFF_FFF8), .INC(4)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus.master)
  );

`ifdef PC_GEN_ALIGN_CHK_EN
  localparam logic [31:0] EXP_MIS_PC0   = 32'h0000_0304;
  localparam logic [31:0] EXP_MIS_PC1   = 32'h0000_0308;
  localparam logic [31:0] EXP_MIS_FLT0  = 32'h1;
`else
  localparam logic [31:0] EXP_MIS_PC0   = 32'h0000_0102;
  localparam logic [31:0] EXP_MIS_PC1   = 32'h0000_0106;
  localparam logic [31:0] EXP_MIS_FLT0  = 32'h0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.br_valid    = 1'b0;
    bus.br_pc       = '0;
    bus.trap_valid  = 1'b0;
    bus.trap_pc     = '0;
    bus.req_ready   = 1'b1;
    wbus.stall      = 1'b0;
    wbus.br_valid   = 1'b0;
    wbus.br_pc      = '0;
    wbus.trap_valid = 1'b0;
    wbus.trap_pc    = '0;
    wbus.req_ready  = 1'b1;

    step();
    step();
    check("rst_valid", 32'(bus.req_valid), 32'h0);
    check("rst_pc", bus.req_pc, 32'h0);
    check("rst_pc_nxt", bus.pc_nxt, 32'h4);
    check("rst_fault", 32'(bus.misalign_fault), 32'h0);

    // Boot, then sequential fetch
    rst = 1'b0;
    check("boot_valid", 32'(bus.req_valid), 32'h0);
    check("wrap_boot_pc", wbus.req_pc, 32'hFFFF_FFF8);
    step();
    check("run_valid", 32'(bus.req_valid), 32'h1);
    check("seq_pc0", bus.req_pc, 32'h0);
    check("seq_nxt0", bus.pc_nxt, 32'h4);
    check("wrap_pc0", wbus.req_pc, 32'hFFFF_FFF8);
    check("wrap_valid", 32'(wbus.req_valid), 32'h1);
    step();
    check("seq_pc1", bus.req_pc, 32'h4);
    check("seq_nxt1", bus.pc_nxt, 32'h8);
    check("wrap_pc1", wbus.req_pc, 32'hFFFF_FFFC);
    check("wrap_nxt1", wbus.pc_nxt, 32'h0);
    step();
    check("seq_pc2", bus.req_pc, 32'h8);
    check("wrap_pc2", wbus.req_pc, 32'h0);

    // Stalled request with a branch arriving mid-stall
    bus.req_ready = 1'b0;
    step();
    check("hold_req_c0", bus.req_pc, 32'h8);
    bus.br_valid = 1'b1;
    bus.br_pc    = 32'h100;
    step();
    check("hold_req_c1", bus.req_pc, 32'h8);
    check("hold_req_valid", 32'(bus.req_valid), 32'h1);
    bus.br_valid = 1'b0;
    step();
    check("hold_req_c2", bus.req_pc, 32'h8);
    bus.req_ready = 1'b1;
    step();
    check("pend_applied", bus.req_pc, 32'h100);

    // Simultaneous branch and trap
    bus.br_valid   = 1'b1;
    bus.br_pc      = 32'h200;
    bus.trap_valid = 1'b1;
    bus.trap_pc    = 32'h80;
    step();
    check("trap_prio", bus.req_pc, 32'h80);
    bus.trap_valid = 1'b0;
    bus.br_pc      = 32'h10;
    step();
    check("br_direct", bus.req_pc, 32'h10);
    bus.br_valid = 1'b0;

    // Decode stall: HOLD and resume
    bus.stall = 1'b1;
    step();
    check("stall_valid", 32'(bus.req_valid), 32'h0);
    check("stall_pc", bus.req_pc, 32'h14);
    step();
    check("stall_pc_held", bus.req_pc, 32'h14);
    bus.stall = 1'b0;
    step();
    check("resume_valid", 32'(bus.req_valid), 32'h1);
    check("resume_pc", bus.req_pc, 32'h14);
    step();
    check("resume_pc1", bus.req_pc, 32'h18);

    // Redirect while in HOLD loads directly
    bus.stall = 1'b1;
    step();
    check("hold2_pc", bus.req_pc, 32'h1C);
    bus.br_valid = 1'b1;
    bus.br_pc    = 32'h40;
    step();
    check("hold_redir_pc", bus.req_pc, 32'h40);
    check("hold_redir_valid", 32'(bus.req_valid), 32'h0);
    bus.br_valid = 1'b0;
    bus.stall    = 1'b0;
    step();
    check("hold2_exit_pc", bus.req_pc, 32'h40);
    check("hold2_exit_valid", 32'(bus.req_valid), 32'h1);

    // Pending trap must survive a later branch
    bus.req_ready  = 1'b0;
    bus.trap_valid = 1'b1;
    bus.trap_pc    = 32'h300;
    step();
    bus.trap_valid = 1'b0;
    bus.br_valid   = 1'b1;
    bus.br_pc      = 32'h400;
    step();
    bus.br_valid  = 1'b0;
    bus.req_ready = 1'b1;
    step();
    check("pend_trap_kept", bus.req_pc, 32'h300);

    // Misaligned branch target
    bus.br_valid = 1'b1;
    bus.br_pc    = 32'h102;
    step();
    check("mis_pc", bus.req_pc, EXP_MIS_PC0);
    check("mis_fault", 32'(bus.misalign_fault), EXP_MIS_FLT0);
    bus.br_valid = 1'b0;
    step();
    check("mis_pc_next", bus.req_pc, EXP_MIS_PC1);
    check("mis_fault_clr", 32'(bus.misalign_fault), 32'h0);

    // Reset mid-request discards the pending redirect
    bus.req_ready = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_pc     = 32'h500;
    step();
    bus.br_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.req_valid), 32'h0);
    check("async_rst_pc", bus.req_pc, 32'h0);
    step();
    rst           = 1'b0;
    bus.req_ready = 1'b1;
    step();
    check("post_rst_pc", bus.req_pc, 32'h0);
    step();
    check("post_rst_no_pend", bus.req_pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
